// File: rtl/draw_node_pkg.sv
// Shared constants for the note-highway renderer: panel geometry, sprite shape, colour bit offsets.
package draw_node_pkg;

  localparam int unsigned NUM_SLOTS  = 10;
  localparam int unsigned NUM_PANELS = 7;
  localparam int unsigned PANEL_BITS = 192;

  // One bit per pixel (p = 8*row + col); byte r is row r.
  // Rows 1 and 6 span cols 2..5, and rows 2..5 span cols 1..6. This gives a rounded 6x6 blob.
  localparam logic [63:0] SPRITE_MASK = 64'h003C_7E7E_7E7E_3C00;

  // Colour channel position inside each 3-bit pixel.
  localparam int unsigned R_OFS = 0;
  localparam int unsigned G_OFS = 1;
  localparam int unsigned B_OFS = 2;

  // Green column 0 of every row, marking the hit line on panel 0.
  localparam logic [PANEL_BITS-1:0] HIT_LINE_MASK = {8{24'h000002}};

endpackage

// File: rtl/draw_node_if.sv
// Note/scroll inputs and the seven rendered panel bitmaps of draw_node.
interface draw_node_if;
  import draw_node_pkg::*;

  logic [NUM_SLOTS-1:0]  red_notes;
  logic [NUM_SLOTS-1:0]  blue_notes;
  logic [2:0]            offset;
  logic [PANEL_BITS-1:0] bitmap0;
  logic [PANEL_BITS-1:0] bitmap1;
  logic [PANEL_BITS-1:0] bitmap2;
  logic [PANEL_BITS-1:0] bitmap3;
  logic [PANEL_BITS-1:0] bitmap4;
  logic [PANEL_BITS-1:0] bitmap5;
  logic [PANEL_BITS-1:0] bitmap6;

  modport master (
    output red_notes, blue_notes, offset,
    input  bitmap0, bitmap1, bitmap2, bitmap3, bitmap4, bitmap5, bitmap6
  );

  modport slave (
    input  red_notes, blue_notes, offset,
    output bitmap0, bitmap1, bitmap2, bitmap3, bitmap4, bitmap5, bitmap6
  );

endinterface

// File: rtl/draw_node_panel.sv
// Combinational renderer for one 8x8 RGB panel: note sprite in red and/or blue, or blank.
module draw_node_panel
  import draw_node_pkg::*;
(
  input  logic                  red,
  input  logic                  blue,
  input  logic                  blank,
  output logic [PANEL_BITS-1:0] panel
);

  // Paint every sprite pixel with the requested channels; green is never driven here.
  always_comb begin
    panel = '0;
    for (int p = 0; p < 64; p++) begin
      if (SPRITE_MASK[p] && !blank) begin
        panel[3*p + R_OFS] = red;
        panel[3*p + B_OFS] = blue;
      end
    end
  end

endmodule

// File: rtl/draw_node.sv
// draw_node: renders 7 scrolling note panels from a 10-slot red/blue note track.
// Panel k shows slot k+offset. A slot past the end of the track gives a blank panel.
// All bitmaps are registered, so they are valid one clock after the inputs are sampled.
// Optional build macro: DRAW_NODE_HIT_LINE_EN adds a green hit line on column 0 of panel 0.
module draw_node
  import draw_node_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  draw_node_if.slave   bus
);

  logic [15:0]           red_ext;
  logic [15:0]           blue_ext;
  logic [NUM_PANELS-1:0] sel_red;
  logic [NUM_PANELS-1:0] sel_blue;
  logic [NUM_PANELS-1:0] sel_blank;
  logic [PANEL_BITS-1:0] panel_d [NUM_PANELS];
  logic [PANEL_BITS-1:0] frame_d [NUM_PANELS];
  logic [PANEL_BITS-1:0] frame_q [NUM_PANELS];

  // Zero-pad so that a slot index past the track (up to 13) reads an absent note.
  assign red_ext  = {{(16 - NUM_SLOTS){1'b0}}, bus.red_notes};
  assign blue_ext = {{(16 - NUM_SLOTS){1'b0}}, bus.blue_notes};

  for (genvar k = 0; k < NUM_PANELS; k++) begin : g_panel
    logic [3:0] slot;
    assign slot         = 4'(k) + {1'b0, bus.offset};
    assign sel_blank[k] = (slot >= 4'(NUM_SLOTS));
    assign sel_red[k]   = red_ext[slot];
    assign sel_blue[k]  = blue_ext[slot];

    draw_node_panel u_panel (
      .red   (sel_red[k]),
      .blue  (sel_blue[k]),
      .blank (sel_blank[k]),
      .panel (panel_d[k])
    );
  end

  // Next frame: rendered panels, plus the hit line on panel 0 when enabled.
  always_comb begin
    for (int k = 0; k < NUM_PANELS; k++) begin
      frame_d[k] = panel_d[k];
    end
`ifdef DRAW_NODE_HIT_LINE_EN
    frame_d[0] = panel_d[0] | HIT_LINE_MASK;
`else
    frame_d[0] = panel_d[0];
`endif
  end

  // Output registers. Reset clears the display at once and drops any pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PANELS; k++) begin
        frame_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PANELS; k++) begin
        frame_q[k] <= frame_d[k];
      end
    end
  end

  assign bus.bitmap0 = frame_q[0];
  assign bus.bitmap1 = frame_q[1];
  assign bus.bitmap2 = frame_q[2];
  assign bus.bitmap3 = frame_q[3];
  assign bus.bitmap4 = frame_q[4];
  assign bus.bitmap5 = frame_q[5];
  assign bus.bitmap6 = frame_q[6];

endmodule

// File: tb/tb_draw_node.sv
// Directed self-checking bench for draw_node with hand-derived sprite geometry.
module tb_draw_node;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  draw_node_if bus ();

  draw_node dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] get_bm(input int k);
    case (k)
      0: return bus.bitmap0;
      1: return bus.bitmap1;
      2: return bus.bitmap2;
      3: return bus.bitmap3;
      4: return bus.bitmap4;
      5: return bus.bitmap5;
      default: return bus.bitmap6;
    endcase
  endfunction

  // Sprite shape from geometry: the inner 6x6 square with its four corners removed.
  function automatic bit sprite_pix(input int r, input int c);
    bit inside_sq;
    bit corner;
    inside_sq = (r >= 1) && (r <= 6) && (c >= 1) && (c <= 6);
    corner    = ((r == 1) || (r == 6)) && ((c == 1) || (c == 6));
    return inside_sq && !corner;
  endfunction

  function automatic logic [191:0] exp_panel(input int k, input logic [9:0] rn,
                                             input logic [9:0] bn, input int off);
    logic [191:0] v;
    int s;
    v = '0;
    s = k + off;
    if (s < 10) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          if (sprite_pix(r, c)) begin
            v[3*(8*r + c)]     = rn[s];
            v[3*(8*r + c) + 2] = bn[s];
          end
        end
      end
    end
`ifdef DRAW_NODE_HIT_LINE_EN
    if (k == 0) begin
      for (int r = 0; r < 8; r++) v[24*r + 1] = 1'b1;
    end
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] rn, input logic [9:0] bn,
                           input int off);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s bm%0d", tag, k), get_bm(k), exp_panel(k, rn, bn, off));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s bm%0d", tag, k), get_bm(k), '0);
    end
  endtask

  // Drive inputs, then sample one edge later, away from the edge.
  task automatic apply(input logic [9:0] rn, input logic [9:0] bn, input logic [2:0] off);
    bus.red_notes  = rn;
    bus.blue_notes = bn;
    bus.offset     = off;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [191:0] bm;
    int           rcount;
    logic [191:0] one_pix;
    compared   = 0;
    mismatched = 0;
    rst_n          = 1'b1;
    bus.red_notes  = '0;
    bus.blue_notes = '0;
    bus.offset     = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    #2;
    rst_n = 1'b1;

    // Single red note in slot 0.
    apply(10'b0000000001, 10'b0, 3'd0);
    bm = bus.bitmap0;
    check("pix12_R", {191'b0, bm[30]}, 192'd1);
    check("pix12_B", {191'b0, bm[32]}, 192'd0);
    check("pix11_R", {191'b0, bm[27]}, 192'd0);
    rcount = 0;
    for (int p = 0; p < 64; p++) rcount += int'(bm[3*p]);
    check("r_count", 192'(rcount), 192'd32);
    check_all("slot0_red", 10'b0000000001, 10'b0, 0);

    // Scrolling one note across panels.
    apply(10'b0000001000, 10'b0, 3'd3);
    check_all("s3_off3", 10'b0000001000, 10'b0, 3);
    apply(10'b0000001000, 10'b0, 3'd2);
    check_all("s3_off2", 10'b0000001000, 10'b0, 2);

    // Red and blue on the same slot give magenta.
    apply(10'b0000100000, 10'b0000100000, 3'd5);
    bm = bus.bitmap0;
    check("mag_R30", {191'b0, bm[30]}, 192'd1);
    check("mag_B32", {191'b0, bm[32]}, 192'd1);
    one_pix = bm & {64{3'b010}};
`ifdef DRAW_NODE_HIT_LINE_EN
    check("mag_G", one_pix, {8{24'h000002}});
`else
    check("mag_G", one_pix, '0);
`endif
    check_all("magenta", 10'b0000100000, 10'b0000100000, 5);

    // Last slot near the end of the scroll range; offset 7 is not clamped.
    apply(10'b1000000000, 10'b0, 3'd6);
    check_all("s9_off6", 10'b1000000000, 10'b0, 6);
    apply(10'b1000000000, 10'b0, 3'd7);
    check_all("s9_off7", 10'b1000000000, 10'b0, 7);

    // Mixed track at several offsets.
    apply(10'b1010110011, 10'b0110011101, 3'd0);
    check_all("mix_off0", 10'b1010110011, 10'b0110011101, 0);
    apply(10'b1010110011, 10'b0110011101, 3'd1);
    check_all("mix_off1", 10'b1010110011, 10'b0110011101, 1);
    apply(10'b1010110011, 10'b0110011101, 3'd4);
    check_all("mix_off4", 10'b1010110011, 10'b0110011101, 4);

    // Outputs hold until the next edge even when the inputs change.
    bus.red_notes  = 10'b0101010101;
    bus.blue_notes = 10'b0;
    bus.offset     = 3'd2;
    #2;
    check_all("hold", 10'b1010110011, 10'b0110011101, 4);
    @(posedge clk);
    #1;
    check_all("hold_upd", 10'b0101010101, 10'b0, 2);

    // Empty track: only the optional hit line.
    apply(10'b0, 10'b0, 3'd3);
    check_all("empty", 10'b0, 10'b0, 3);

    // Asynchronous reset mid-operation, then recovery.
    apply(10'b1111111111, 10'b0101010101, 3'd0);
    check_all("pre_rst", 10'b1111111111, 10'b0101010101, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    check_zero("rst_edge");
    #2;
    rst_n = 1'b1;
    #1;
    check_zero("rel_noedge");
    @(posedge clk);
    #1;
    check_all("post_rst", 10'b1111111111, 10'b0101010101, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
